// File: rtl/sprite_pixel_engine.sv
// Animated sprite pixel pipeline: box hit -> ROM address -> palette colour; 3-cycle latency, no backpressure.
// Horizontal mirroring is built only when SPRITE_FLIP_EN is defined; flip_h is otherwise ignored.
module sprite_pixel_engine #(
    parameter int SPR_W  = 64,
    parameter int SPR_H  = 64,
    parameter int FRAMES = 4,
    parameter int IDX_W  = 3,
    parameter int HOLD   = 6,
    parameter int LOOP   = 1,
    localparam int ADDR_W = $clog2(SPR_W*SPR_H*FRAMES)
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    input  logic              blank,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic              flip_h,
    input  logic              frame_tick,
    input  logic              anim_start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    input  logic              pal_we,
    input  logic [IDX_W-1:0]  pal_waddr,
    input  logic [11:0]       pal_wdata,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              pixel_valid,
    output logic              anim_done
);

    localparam int FR_W   = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int PAL_N  = 2**IDX_W;

    logic [FR_W-1:0]   r_frame;
    logic [HOLD_W-1:0] r_hold;
    logic              r_done;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_vld0;
    logic              r_vld1;
    logic [11:0]       r_rgb;
    logic              r_pix_vld;
    logic [11:0]       r_pal [PAL_N];

    logic [10:0]       w_x_end;
    logic [10:0]       w_y_end;
    logic              w_hit;
    logic [9:0]        w_dx;
    logic [9:0]        w_dy;
    logic [9:0]        w_col;
    logic [ADDR_W-1:0] w_addr;
    logic              w_hold_end;
    logic              w_last;
    logic [FR_W-1:0]   w_frame_nxt;

    // 11-bit box limits so a sprite near x/y=1023 cannot wrap into a low-coordinate hit
    assign w_x_end = {1'b0, sprite_x} + 11'(SPR_W);
    assign w_y_end = {1'b0, sprite_y} + 11'(SPR_H);
    assign w_hit   = (draw_x >= sprite_x) && ({1'b0, draw_x} < w_x_end) &&
                     (draw_y >= sprite_y) && ({1'b0, draw_y} < w_y_end);
    assign w_dx    = draw_x - sprite_x;
    assign w_dy    = draw_y - sprite_y;

`ifdef SPRITE_FLIP_EN
    assign w_col = flip_h ? (10'(SPR_W-1) - w_dx) : w_dx;
`else
    logic w_unused_flip;
    assign w_unused_flip = flip_h;
    assign w_col = w_dx;
`endif

    assign w_addr = ADDR_W'(int'(r_frame) * (SPR_W*SPR_H) + int'(w_dy) * SPR_W + int'(w_col));

    // Stage 0/1: address register plus a valid that tracks each address to its rom_q sample
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rom_addr <= '0;
            r_vld0     <= 1'b0;
            r_vld1     <= 1'b0;
        end else begin
            if (w_hit)
                r_rom_addr <= w_addr;
            r_vld0 <= w_hit && blank;
            r_vld1 <= r_vld0;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rgb     <= '0;
            r_pix_vld <= 1'b0;
        end else if (r_vld1 && (rom_q != '0)) begin
            r_rgb     <= r_pal[rom_q];
            r_pix_vld <= 1'b1;
        end else begin
            r_rgb     <= '0;
            r_pix_vld <= 1'b0;
        end
    end

    // Palette read above sees pre-edge contents, so same-cycle write returns old data
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PAL_N; i++)
                r_pal[i] <= '0;
        end else if (pal_we) begin
            r_pal[pal_waddr] <= pal_wdata;
        end
    end

    always_comb begin
        w_hold_end  = (r_hold == HOLD_W'(HOLD-1));
        w_last      = (r_frame == FR_W'(FRAMES-1));
        w_frame_nxt = r_frame;
        if (!w_last)
            w_frame_nxt = r_frame + 1'b1;
        else if (LOOP != 0)
            w_frame_nxt = '0;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame <= '0;
            r_hold  <= '0;
            r_done  <= 1'b0;
        end else if (anim_start) begin
            r_frame <= '0;
            r_hold  <= '0;
            r_done  <= 1'b0;
        end else if (frame_tick) begin
            if (w_hold_end) begin
                r_hold  <= '0;
                r_frame <= w_frame_nxt;
                r_done  <= (LOOP == 0) && (w_frame_nxt == FR_W'(FRAMES-1));
            end else begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

    assign rom_addr    = r_rom_addr;
    assign red         = r_rgb[11:8];
    assign green       = r_rgb[7:4];
    assign blue        = r_rgb[3:0];
    assign pixel_valid = r_pix_vld;
    assign anim_done   = r_done;

endmodule

// File: tb/tb_sprite_pixel_engine.sv
// Bench for sprite_pixel_engine: looping and one-shot instances share stimulus; a frame-count model predicts outputs.
module tb_sprite_pixel_engine;

    localparam int SPR_W  = 64;
    localparam int SPR_H  = 64;
    localparam int FRAMES = 4;
    localparam int IDX_W  = 3;
    localparam int HOLD   = 6;
    localparam int ADDR_W = 14;
    localparam int ROM_N  = SPR_W*SPR_H*FRAMES;
`ifdef SPRITE_FLIP_EN
    localparam int EXP_FLIP_ADDR = 63;
`else
    localparam int EXP_FLIP_ADDR = 0;
`endif

    logic              vga_clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [9:0]        draw_x, draw_y, sprite_x, sprite_y;
    logic              blank, flip_h, frame_tick, anim_start, pal_we;
    logic [IDX_W-1:0]  pal_waddr;
    logic [11:0]       pal_wdata;
    logic [ADDR_W-1:0] rom_addr0, rom_addr1;
    logic [IDX_W-1:0]  rom_q0 = '0;
    logic [IDX_W-1:0]  rom_q1 = '0;
    logic [3:0]        red0, green0, blue0, red1, green1, blue1;
    logic              pv0, pv1, done0, done1;

    logic [IDX_W-1:0]  rom_mem [ROM_N];

    typedef struct {
        bit vld;
        int idx;
        int col;
    } ent_t;

    int   checks   = 0;
    int   failures = 0;
    int   ticks;
    int   exp_a0, exp_a1;
    logic [11:0] mpal [8];
    ent_t q[$];

    always #5 vga_clk = ~vga_clk;

    // Synchronous sprite ROM: data one cycle after the address
    always @(posedge vga_clk) begin
        rom_q0 <= rom_mem[rom_addr0];
        rom_q1 <= rom_mem[rom_addr1];
    end

    sprite_pixel_engine #(.SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES), .IDX_W(IDX_W),
                          .HOLD(HOLD), .LOOP(1)) dut_loop (
        .vga_clk(vga_clk), .reset_n(reset_n), .draw_x(draw_x), .draw_y(draw_y),
        .blank(blank), .sprite_x(sprite_x), .sprite_y(sprite_y), .flip_h(flip_h),
        .frame_tick(frame_tick), .anim_start(anim_start), .rom_addr(rom_addr0),
        .rom_q(rom_q0), .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
        .red(red0), .green(green0), .blue(blue0), .pixel_valid(pv0), .anim_done(done0));

    sprite_pixel_engine #(.SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES), .IDX_W(IDX_W),
                          .HOLD(HOLD), .LOOP(0)) dut_stop (
        .vga_clk(vga_clk), .reset_n(reset_n), .draw_x(draw_x), .draw_y(draw_y),
        .blank(blank), .sprite_x(sprite_x), .sprite_y(sprite_y), .flip_h(flip_h),
        .frame_tick(frame_tick), .anim_start(anim_start), .rom_addr(rom_addr1),
        .rom_q(rom_q1), .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
        .red(red1), .green(green1), .blue(blue1), .pixel_valid(pv1), .anim_done(done1));

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Frame number derived purely from the count of ticks since start/reset
    function automatic int frame_of(input bit loop_en);
        int f;
        f = ticks / HOLD;
        if (loop_en)
            return f % FRAMES;
        return (f > FRAMES-1) ? FRAMES-1 : f;
    endfunction

    task automatic model_reset();
        ticks  = 0;
        exp_a0 = 0;
        exp_a1 = 0;
        q.delete();
        for (int i = 0; i < 8; i++)
            mpal[i] = '0;
    endtask

    task automatic set_idle();
        draw_x = '0; draw_y = '0; sprite_x = 10'd500; sprite_y = 10'd500;
        blank = 1'b0; flip_h = 1'b0; frame_tick = 1'b0; anim_start = 1'b0;
        pal_we = 1'b0; pal_waddr = '0; pal_wdata = '0;
    endtask

    // One pixel clock: check due outputs, then drive this cycle's inputs and extend the model
    task automatic cyc(input int dx, input int dy, input bit bl, input int sx, input int sy,
                       input bit fl, input bit tk, input bit st,
                       input bit we, input int wa, input int wd);
        ent_t e;
        int   col, k;
        bit   hit;
        @(negedge vga_clk);
        if (q.size() == 3) begin
            e = q.pop_front();
            chk("pixel_valid", int'(pv0), (e.vld && e.idx != 0) ? 1 : 0);
            chk("rgb", int'({red0, green0, blue0}), (e.vld && e.idx != 0) ? e.col : 0);
        end
        chk("rom_addr_loop", int'(rom_addr0), exp_a0);
        chk("rom_addr_stop", int'(rom_addr1), exp_a1);
        chk("anim_done_loop", int'(done0), 0);
        chk("anim_done_stop", int'(done1), (ticks / HOLD >= FRAMES-1) ? 1 : 0);
        if (q.size() >= 2) begin
            k = q.size() - 2;
            e = q[k];
            e.col = int'(mpal[e.idx]);
            q[k] = e;
        end
        draw_x = 10'(dx); draw_y = 10'(dy); blank = bl;
        sprite_x = 10'(sx); sprite_y = 10'(sy); flip_h = fl;
        frame_tick = tk; anim_start = st;
        pal_we = we; pal_waddr = 3'(wa); pal_wdata = 12'(wd);
        hit = (dx >= sx) && (dx < sx + SPR_W) && (dy >= sy) && (dy < sy + SPR_H);
        e.vld = hit && bl;
        e.idx = 0;
        e.col = 0;
        if (hit) begin
            col = dx - sx;
`ifdef SPRITE_FLIP_EN
            if (fl)
                col = SPR_W - 1 - col;
`endif
            exp_a0 = frame_of(1'b1) * SPR_W * SPR_H + (dy - sy) * SPR_W + col;
            exp_a1 = frame_of(1'b0) * SPR_W * SPR_H + (dy - sy) * SPR_W + col;
            e.idx  = int'(rom_mem[exp_a0]);
        end
        q.push_back(e);
        if (we)
            mpal[wa] = 12'(wd);
        if (st)
            ticks = 0;
        else if (tk)
            ticks++;
    endtask

    task automatic idle(input bit tk = 1'b0, input bit st = 1'b0);
        cyc(0, 0, 1'b0, 500, 500, 1'b0, tk, st, 1'b0, 0, 0);
    endtask

    task automatic probe(input string tag, input int dx, input int dy, input int sx, input int sy,
                         input int exp_v, input int exp_rgb);
        cyc(dx, dy, 1'b1, sx, sy, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        repeat (3) idle();
        chk({tag, "_vld"}, int'(pv0), exp_v);
        chk({tag, "_rgb"}, int'({red0, green0, blue0}), exp_rgb);
    endtask

    task automatic do_reset();
        @(negedge vga_clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_rom_addr", int'(rom_addr0), 0);
        chk("rst_rom_addr_stop", int'(rom_addr1), 0);
        chk("rst_rgb", int'({red0, green0, blue0}), 0);
        chk("rst_pixel_valid", int'(pv0), 0);
        chk("rst_anim_done_stop", int'(done1), 0);
        set_idle();
        repeat (2) @(negedge vga_clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic rnd_cycle();
        int sx, sy;
        sx = int'($urandom_range(0, 1023));
        sy = int'($urandom_range(0, 1023));
        cyc((sx + int'($urandom_range(0, 79)) - 8) & 1023,
            (sy + int'($urandom_range(0, 79)) - 8) & 1023,
            $urandom_range(0, 7) != 0, sx, sy, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0,
            $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 4095)));
    endtask

    initial begin
        for (int i = 0; i < ROM_N; i++)
            rom_mem[i] = 3'($urandom_range(0, 7));
        rom_mem[0] = 3'd5;
        rom_mem[1] = 3'd0;
        set_idle();
        model_reset();
        do_reset();

        cyc(0, 0, 1'b0, 500, 500, 1'b0, 1'b0, 1'b0, 1'b1, 5, 'hF80);
        probe("pal5_hit", 100, 50, 100, 50, 1, 'hF80);
        probe("index0", 101, 50, 100, 50, 0, 0);
        probe("left_of_box", 99, 50, 100, 50, 0, 0);

        idle(1'b0, 1'b1);
        cyc(100, 50, 1'b1, 100, 50, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        idle();
        chk("flip_origin_addr", int'(rom_addr0), EXP_FLIP_ADDR);

        for (int dx = 999; dx <= 1023; dx++)
            cyc(dx, 5, 1'b1, 1000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        for (int dx = 0; dx <= 40; dx++)
            cyc(dx, 5, 1'b1, 1000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

        idle(1'b0, 1'b1);
        for (int k = 0; k <= 24; k++)
            cyc(100, 50, 1'b1, 100, 50, 1'b0, k < 24, 1'b0, 1'b0, 0, 0);
        idle();
        chk("loop_wrapped_addr", int'(rom_addr0), 0);
        chk("stop_last_addr", int'(rom_addr1), 3 * SPR_W * SPR_H);
        chk("stop_anim_done", int'(done1), 1);
        idle(1'b1, 1'b1);
        idle();
        chk("start_beats_tick_done", int'(done1), 0);
        cyc(100, 50, 1'b1, 100, 50, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        idle();
        chk("start_beats_tick_addr", int'(rom_addr1), 0);

        repeat (1200) rnd_cycle();
        do_reset();
        probe("pal_cleared", 100, 50, 100, 50, 1, 0);
        repeat (800) rnd_cycle();
        repeat (3) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_pixel_engine.md
SPRITE_PIXEL_ENGINE -- requirements
Module: sprite_pixel_engine

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 The block SHALL have these parameters: SPR_W, 64, sprite width in pixels; SPR_H, 64, sprite height; FRAMES, 4, animation frames; IDX_W, 3, palette index bits; HOLD, 6, frame_tick pulses per animation frame; LOOP, 1, 1 = wrap at last frame, 0 = stop at last frame.
REQ-003 ADDR_W SHALL be derived as clog2(SPR_W*SPR_H*FRAMES).
REQ-004 Ports SHALL be, clock and reset first:
- vga_clk  in  1  pixel clock
- reset_n  in  1  async active-low reset
- draw_x, draw_y  in  10 each  current pixel
- blank  in  1  high = active display
- sprite_x, sprite_y  in  10 each  sprite top-left corner
- flip_h  in  1  horizontal mirror request
- frame_tick  in  1  one-cycle pulse per video frame
- anim_start  in  1  restart-animation pulse
- rom_addr  out  ADDR_W  sprite ROM address, registered
- rom_q  in  IDX_W  ROM data, 1 cycle after rom_addr
- pal_we  in  1  palette write enable
- pal_waddr  in  IDX_W  palette write index
- pal_wdata  in  12  {r,g,b} 4 bits each
- red, green, blue  out  4 each  pixel colour
- pixel_valid  out  1  opaque sprite pixel present
- anim_done  out  1  LOOP=0 and last frame reached

Function
REQ-005 Stage 0 SHALL compute hit = (sprite_x <= draw_x < sprite_x+SPR_W) and (sprite_y <= draw_y < sprite_y+SPR_H), using 11-bit sums so no overflow occurs at the screen edge.
REQ-006 Stage 0 SHALL register rom_addr = frame*SPR_W*SPR_H + row*SPR_W + col, with row = draw_y-sprite_y and col = draw_x-sprite_x; rom_addr SHALL hold its previous value when hit=0.
REQ-007 hit and blank SHALL be delayed alongside the data so that each arrives aligned with its own rom_q sample.
REQ-008 Stage 2 SHALL register red/green/blue from palette[rom_q]; the total latency from draw_x/draw_y to the colour outputs SHALL be exactly 3 cycles.
REQ-009 Index 0 SHALL be transparent: when index is 0, hit=0 or blank=0, the colour outputs SHALL be 0 and pixel_valid SHALL be 0; otherwise pixel_valid SHALL be 1.
REQ-010 The palette SHALL have 2^IDX_W entries of 12 bits each, written synchronously on pal_we; a read and a write to the same entry in the same cycle SHALL return the old data.
REQ-011 Animation SHALL use a hold counter that increments on frame_tick; when it reaches HOLD-1 it SHALL clear to 0 and advance the frame.
REQ-012 Frame advance SHALL wrap from FRAMES-1 to 0 when LOOP=1; when LOOP=0 the frame SHALL stay at FRAMES-1 and anim_done SHALL be set.
REQ-013 anim_start SHALL clear the frame, the hold counter and anim_done; if anim_start and frame_tick occur in the same cycle, anim_start SHALL win.
REQ-014 A frame change SHALL take effect on the first rom_addr registered after the change, and in-flight pixels SHALL keep their old frame.

Reset
REQ-015 While reset_n is low, the following SHALL be 0: rom_addr, colour outputs, pixel_valid, anim_done, frame, hold counter, pipeline valids and all palette entries.
REQ-016 On reset deassertion, the first valid output SHALL appear 3 cycles after the first in-box, active pixel.

Configuration
REQ-017 When SPRITE_FLIP_EN is defined, flip_h=1 SHALL make col = SPR_W-1-(draw_x-sprite_x).
REQ-018 When SPRITE_FLIP_EN is undefined, flip_h SHALL be ignored and no mirror logic SHALL be built; the port SHALL remain present in both cases.

Verification
REQ-019 Write palette[5]=12'hF80, place the sprite at (100,50), return rom_q=5 at draw (100,50) -> red=F, green=8, blue=0, pixel_valid=1, exactly 3 cycles later.
REQ-020 rom_q=0 inside the box, and a separate pixel at draw_x=99 -> colour 0 and pixel_valid=0 for both.
REQ-021 Set sprite_x=1000 with SPR_W=64 and sweep draw_x 999..1023 -> no wrap-around false hit at low draw_x, and hit at 1000..1023.
REQ-022 LOOP=1, HOLD=6, FRAMES=4, apply 24 frame_ticks -> frame sequence 0,1,2,3,0, with rom_addr base stepping by 4096; LOOP=0 -> frame stays 3 with anim_done=1, and anim_start with a simultaneous frame_tick -> frame 0 and anim_done=0.
REQ-023 With SPRITE_FLIP_EN, flip_h=1 at col 0 row 0 -> rom_addr=63; without the macro -> rom_addr=0.
REQ-024 Assert reset_n low in the middle of a line -> all outputs 0 asynchronously, and the palette reads 0 after release.
